// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, binary grant id and optional hold limit.
// Define ONEHOT_ARB_CHECK_EN to build in the sticky one-hot checker behind onehot_err.
module onehot_rr_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 0,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               timeout_o,
    output logic               onehot_err
);

    // state   | meaning
    // IDLE    | no owner; pick the next requester upward from ptr
    // GRANTED | grant held until release, withdrawal or hold limit
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [0:0]        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   next_ptr;
    logic              win_found;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;
    logic              owner_req;
    logic              release_any;
    int                scan_idx;

    // Scan downward in offset so the lowest offset from ptr is the last write and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    generate
        if (MAX_HOLD > 0) begin : g_hold
            assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
        end else begin : g_no_hold
            assign hold_hit = 1'b0;
        end
    endgenerate

    assign owner_req   = req[grant_id];
    assign release_any = (state == ST_GRANTED) && (release_i || !owner_req || hold_hit);
    assign timeout_o   = (state == ST_GRANTED) && hold_hit && !release_i && owner_req;
    assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant       <= NUM_REQ'(1) << win_id;
                        grant_id    <= win_id;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (release_any) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= next_ptr;
                        hold_cnt    <= '0;
                        state       <= ST_IDLE;
                    end else if (MAX_HOLD > 0) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ONEHOT_ARB_CHECK_EN
    logic onehot_bad;

    assign onehot_bad = ((grant & (grant - NUM_REQ'(1))) != '0) ||
                        (grant_valid != (grant != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err <= 1'b0;
        end else if (onehot_bad) begin
            onehot_err <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && onehot_bad) begin
            $error("onehot_rr_arbiter: grant %h not one-hot or grant_valid inconsistent", grant);
        end
    end
`else
    assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter (NUM_REQ=8, MAX_HOLD=4); inputs driven on the falling edge.
// Expected outputs are queued as stimulus is applied and compared 1 time unit later.
module tb_onehot_rr_arbiter;

    typedef struct packed {
        logic [7:0] req;
        logic       rel;
        logic [7:0] g;
        logic       v;
        logic [2:0] id;
        logic       t;
    } row_t;

    typedef struct packed {
        logic [7:0] g;
        logic       v;
        logic [2:0] id;
        logic       t;
        logic       e;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       release_i;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout_o;
    logic       onehot_err;

    int   checks;
    int   errors;
    obs_t sb[$];

    onehot_rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .release_i  (release_i),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .timeout_o  (timeout_o),
        .onehot_err (onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of stimulus and queue the outputs expected in that cycle.
    task automatic apply(input row_t r);
        @(negedge clk);
        req       = r.req;
        release_i = r.rel;
        sb.push_back('{r.g, r.v, r.id, r.t, 1'b0});
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply('{8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0});
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got g=%h v=%b id=%0d t=%b e=%b, want g=%h v=%b id=%0d t=%b e=%b",
                         i, o.g, o.v, o.id, o.t, o.e, e.g, e.v, e.id, e.t, e.e);
            end
        end
        apply('{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0});
        rst_n = 1'b1;
        #1;
        e = sb.pop_front();
        o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_exit: got g=%h v=%b id=%0d, want g=%h v=%b id=%0d", o.g, o.v, o.id, e.g, e.v, e.id);
        end
    endtask

    task automatic test_round_robin();
        obs_t e, o;
        row_t r;
        logic [2:0] id;
        apply('{8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0});
        #1;
        e = sb.pop_front();
        o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rr_start: got g=%h v=%b id=%0d, want g=%h v=%b id=%0d", o.g, o.v, o.id, e.g, e.v, e.id);
        end
        for (int k = 0; k < 9; k++) begin
            id = 3'(k % 8);
            for (int p = 0; p < 3; p++) begin
                r.req = (p == 2 && k == 8) ? 8'h00 : 8'hFF;
                r.rel = (p == 1);
                r.g   = (p == 2) ? 8'h00 : (8'h01 << id);
                r.v   = (p != 2);
                r.id  = id;
                r.t   = 1'b0;
                apply(r);
                #1;
                e = sb.pop_front();
                o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL round_robin[%0d.%0d]: got g=%h v=%b id=%0d t=%b, want g=%h v=%b id=%0d t=%b",
                             k, p, o.g, o.v, o.id, o.t, e.g, e.v, e.id, e.t);
                end
            end
        end
    endtask

    task automatic test_single();
        row_t tbl [5];
        obs_t e, o;
        tbl = '{'{8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0},
                '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0},
                '{8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0},
                '{8'h00, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(tbl[i]);
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single[%0d]: got g=%h v=%b id=%0d t=%b, want g=%h v=%b id=%0d t=%b",
                         i, o.g, o.v, o.id, o.t, e.g, e.v, e.id, e.t);
            end
        end
    endtask

    task automatic test_pointer_skip();
        row_t tbl [5];
        obs_t e, o;
        tbl = '{'{8'h12, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0},
                '{8'h12, 1'b1, 8'h10, 1'b1, 3'd4, 1'b0},
                '{8'h12, 1'b0, 8'h00, 1'b0, 3'd4, 1'b0},
                '{8'h12, 1'b1, 8'h02, 1'b1, 3'd1, 1'b0},
                '{8'h00, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(tbl[i]);
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pointer_skip[%0d]: got g=%h v=%b id=%0d t=%b, want g=%h v=%b id=%0d t=%b",
                         i, o.g, o.v, o.id, o.t, e.g, e.v, e.id, e.t);
            end
        end
    endtask

    task automatic test_withdrawal();
        row_t tbl [7];
        obs_t e, o;
        tbl = '{'{8'h04, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0},
                '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0},
                '{8'h00, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0},
                '{8'h09, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0},
                '{8'h09, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0},
                '{8'h00, 1'b1, 8'h08, 1'b1, 3'd3, 1'b0},
                '{8'h00, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0}};
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i]);
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL withdrawal[%0d]: got g=%h v=%b id=%0d t=%b, want g=%h v=%b id=%0d t=%b",
                         i, o.g, o.v, o.id, o.t, e.g, e.v, e.id, e.t);
            end
        end
    endtask

    task automatic test_timeout();
        row_t tbl [17];
        obs_t e, o;
        tbl = '{'{8'h01, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b1},
                '{8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h01, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h00, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0},
                '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}};
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i]);
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got g=%h v=%b id=%0d t=%b, want g=%h v=%b id=%0d t=%b",
                         i, o.g, o.v, o.id, o.t, e.g, e.v, e.id, e.t);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        row_t tbl [5];
        obs_t e, o;
        tbl = '{'{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'h20, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0},
                '{8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0},
                '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(tbl[i]);
            if (i == 3) rst_n = 1'b1;
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got g=%h v=%b id=%0d t=%b, want g=%h v=%b id=%0d t=%b",
                         i, o.g, o.v, o.id, o.t, e.g, e.v, e.id, e.t);
            end
            if (i == 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({grant, grant_valid, grant_id} !== 12'h000) begin
                    errors++;
                    $display("FAIL reset_async: got g=%h v=%b id=%0d before edge, want g=00 v=0 id=0",
                             grant, grant_valid, grant_id);
                end
            end
        end
        apply('{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0});
        #1;
        e = sb.pop_front();
        o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_mid_end: got g=%h v=%b id=%0d, want g=%h v=%b id=%0d", o.g, o.v, o.id, e.g, e.v, e.id);
        end
    endtask

    task automatic test_onehot_check();
`ifdef ONEHOT_ARB_CHECK_EN
        @(negedge clk);
        req = 8'h00;
        release_i = 1'b0;
        force dut.grant = 8'h12;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (onehot_err !== 1'b1) begin
                errors++;
                $display("FAIL onehot_err[%0d]: got %b, want 1", i, onehot_err);
            end
        end
        release dut.grant;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (onehot_err !== 1'b0) begin
            errors++;
            $display("FAIL onehot_err_clear: got %b, want 0", onehot_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
`else
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            apply('{8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0});
            #1;
            e = sb.pop_front();
            o = {grant, grant_valid, grant_id, timeout_o, onehot_err};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL onehot_tied[%0d]: got g=%h v=%b e=%b, want g=%h v=%b e=%b", i, o.g, o.v, o.e, e.g, e.v, e.e);
            end
        end
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = 8'hFF;
        release_i = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_pointer_skip();
        test_withdrawal();
        test_timeout();
        test_reset_mid_grant();
        test_onehot_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
